// File: rtl/program_counter_unit_pkg.sv
// Shared program-counter definitions: state encoding and default widths used
// across the PC controller, instruction ROM and fetch-side counter.
package pc_pkg;

  localparam int unsigned PC_W     = 12;
  localparam int unsigned PC_CNT_W = 16;

  typedef enum logic [1:0] {
    PC_IDLE = 2'b00,
    PC_RUN  = 2'b01,
    PC_HALT = 2'b10
  } pc_state_t;

endpackage

// File: rtl/program_counter_unit_next_addr.sv
// Next-address generator: PC plus signed branch offset, or PC plus one.
// Purely combinational so a branch-predict path can reuse it.
module pc_next_addr
  import pc_pkg::*;
#(
  parameter int unsigned D = PC_W
) (
  input  logic [D-1:0] prog_ctr,
  input  logic [D-1:0] target,
  input  logic         branch_en,
  output logic [D-1:0] next_addr
);

  // Two's-complement add truncated to D bits equals the signed add mod 2^D.
  always_comb begin
    next_addr = prog_ctr + (branch_en ? target : D'(1));
  end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-side program counter: IDLE -> RUN -> HALT sequencing with start/done
// handshake, relative branches and a saturating retired-instruction count.
module program_counter_unit
  import pc_pkg::*;
#(
  parameter int unsigned D = PC_W,
  parameter int unsigned C = PC_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] start_addr,
  input  logic         stall,
  input  logic         branch_en,
  input  logic [D-1:0] target,
  input  logic         halt,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic [C-1:0] inst_count
);

  pc_state_t    state_q, state_d;
  logic [D-1:0] pc_q, pc_d, next_addr;
  logic [C-1:0] cnt_q, cnt_d, cnt_inc;

  pc_next_addr #(.D(D)) u_next_addr (
    .prog_ctr  (pc_q),
    .target    (target),
    .branch_en (branch_en),
    .next_addr (next_addr)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + C'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PC_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      PC_IDLE, PC_HALT: begin
        if (start) begin
          state_d = PC_RUN;
          pc_d    = start_addr;
          cnt_d   = '0;
        end
      end
      PC_RUN: begin
        // Halt retires but keeps PC; it outranks the branch/increment.
        if (!stall) begin
          cnt_d = cnt_inc;
          if (halt) state_d = PC_HALT;
          else      pc_d    = next_addr;
        end
      end
      default: begin
        state_d = PC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    running    = (state_q == PC_RUN);
    done       = (state_q == PC_HALT);
    prog_ctr   = pc_q;
    inst_count = cnt_q;
  end

endmodule
